// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag index and FSM state definitions shared by the sequential ALU
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_MUL = 4'd3,
    OP_DIV = 4'd4,
    OP_MOD = 4'd5,
    OP_SUB = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_XOR = 4'd9
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  // acc: product / partial remainder; ra: multiplicand / dividend->quotient; rb: multiplier / divisor
  logic [WIDTH-1:0] acc_q, acc_d, ra_q, ra_d, rb_q, rb_d;
  logic             div_q, div_d, run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] src_acc, src_a, src_b;
  logic             src_div, step;
  logic [WIDTH:0]   rem_sh, rem_sub;

  always_comb begin
    done    = run_q && (cnt_q == CW'(WIDTH));
    step    = start || (run_q && !done);
    // The start cycle already performs the first step on the raw operands
    src_acc = start ? '0 : acc_q;
    src_a   = start ? a : ra_q;
    src_b   = start ? b : rb_q;
    src_div = start ? is_div : div_q;
    rem_sh  = {src_acc, src_a[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, src_b};

    acc_d = acc_q;
    ra_d  = ra_q;
    rb_d  = rb_q;
    div_d = div_q;
    cnt_d = cnt_q;
    run_d = start || (run_q && !done);

    if (step) begin
      div_d = src_div;
      cnt_d = start ? CW'(1) : cnt_q + CW'(1);
      if (src_div) begin
        rb_d = src_b;
        if (!rem_sub[WIDTH]) begin
          acc_d = rem_sub[WIDTH-1:0];
          ra_d  = {src_a[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          ra_d  = {src_a[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = src_acc + (src_b[0] ? src_a : '0);
        ra_d  = src_a << 1;
        rb_d  = src_b >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      div_q <= 1'b0;
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      div_q <= div_d;
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  assign product_lo = acc_q;
  assign quotient   = ra_q;
  assign remainder  = acc_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked registered ALU with NZCV flags and iterative MUL/DIV/MOD
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             div_by_zero,
  output logic             busy
);

  alu_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] fast_res, eng_res;
  logic             fast_c, fast_v, fast_dbz, b_zero, shift_over, start;
  logic             eng_done;
  logic [WIDTH-1:0] eng_prod, eng_quot, eng_rem;

  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    diff       = {1'b0, a} - {1'b0, b};
    b_zero     = (b == '0);
    // Any set bit above the shift field, or an in-field value past WIDTH-1, shifts everything out
    shift_over = (|(b >> SHAMT_W)) || (b[SHAMT_W-1:0] > SHAMT_W'(WIDTH - 1));
    fast_res   = '0;
    fast_c     = 1'b0;
    fast_v     = 1'b0;
    fast_dbz   = 1'b0;
    case (opcode)
      OP_AND: fast_res = a & b;
      OP_OR:  fast_res = a | b;
      OP_XOR: fast_res = a ^ b;
      OP_ADD: begin
        fast_res = sum[WIDTH-1:0];
        fast_c   = sum[WIDTH];
        fast_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        fast_res = diff[WIDTH-1:0];
        fast_c   = diff[WIDTH];
        fast_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: fast_res = shift_over ? '0 : (a << b[SHAMT_W-1:0]);
      OP_SHR: fast_res = shift_over ? '0 : (a >> b[SHAMT_W-1:0]);
      OP_DIV: begin
        fast_res = '1;
        fast_dbz = b_zero;
      end
      OP_MOD: begin
        fast_res = a;
        fast_dbz = b_zero;
      end
      default: fast_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_MUL:  eng_res = eng_prod;
      OP_DIV:  eng_res = eng_quot;
      default: eng_res = eng_rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    dbz_d    = dbz_q;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = opcode;
          // Divide-by-zero never enters the engine; its result is fixed and known now
          if (is_iter_op(opcode) && !((opcode != OP_MUL) && b_zero)) begin
            start   = 1'b1;
            state_d = CALC;
          end else begin
            state_d  = DONE;
            result_d = fast_res;
            flags_d  = {fast_res[WIDTH-1], (fast_res == '0), fast_c, fast_v};
            dbz_d    = fast_dbz;
          end
        end
      end
      CALC: begin
        if (eng_done) begin
          state_d  = DONE;
          result_d = eng_res;
          flags_d  = {eng_res[WIDTH-1], (eng_res == '0), 2'b00};
          dbz_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      dbz_q    <= dbz_d;
    end
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_div     (opcode != OP_MUL),
    .a          (a),
    .b          (b),
    .done       (eng_done),
    .product_lo (eng_prod),
    .quotient   (eng_quot),
    .remainder  (eng_rem)
  );

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign flags       = flags_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with directed vectors at WIDTH=32
module tb_alu_seq;
  import alu_pkg::*;

  localparam int  W = 32;
  localparam time T = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   opcode = '0;
  logic         in_ready, out_valid, div_by_zero, busy;
  logic [W-1:0] result;
  logic [3:0]   flags;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .opcode      (opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags       (flags),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         dbz;
    int           lat;
    time          t_acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        if (!prev_valid)
          chk("latency", 64'(($time - exp_q[0].t_acc + T / 2) / T), 64'(exp_q[0].lat));
        chk("result", 64'(result), 64'(exp_q[0].res));
        chk("flags", 64'(flags), 64'(exp_q[0].flg));
        chk("div_by_zero", 64'(div_by_zero), 64'(exp_q[0].dbz));
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    prev_valid <= rst_n && out_valid;
  end

  task automatic wait_ready();
    @(negedge clk);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic [3:0] ef, input logic ed, input int el);
    exp_t e;
    wait_ready();
    opcode   = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    e.res   = er;
    e.flg   = ef;
    e.dbz   = ed;
    e.lat   = el;
    e.t_acc = $time;
    exp_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, 1'b0, 1);
    issue(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b1010, 1'b0, 1);
    issue(OP_AND, 32'hF0F0, 32'h0F0F, 32'h0, 4'b0100, 1'b0, 1);
    issue(OP_OR, 32'hF0F0, 32'h0F0F, 32'hFFFF, 4'b0000, 1'b0, 1);
    issue(OP_XOR, 32'hFF00_FF00, 32'hFFFF_0000, 32'h00FF_FF00, 4'b0000, 1'b0, 1);
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110, 1'b0, 1);
    issue(OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0001, 1'b0, 1);
    issue(OP_SHL, 32'h1, 32'd40, 32'h0, 4'b0100, 1'b0, 1);
    issue(OP_SHL, 32'h1, 32'd31, 32'h8000_0000, 4'b1000, 1'b0, 1);
    issue(OP_SHR, 32'h8000_0000, 32'd31, 32'h1, 4'b0000, 1'b0, 1);
    issue(OP_SHR, 32'hFFFF_FFFF, 32'd32, 32'h0, 4'b0100, 1'b0, 1);
    issue(4'hF, 32'h1234, 32'h5678, 32'h0, 4'b0100, 1'b0, 1);
    drain();

    issue(OP_DIV, 32'd100, 32'd7, 32'd14, 4'b0000, 1'b0, 33);
    issue(OP_MOD, 32'd100, 32'd7, 32'd2, 4'b0000, 1'b0, 33);
    issue(OP_MUL, 32'h1_0000, 32'h1_0000, 32'h0, 4'b0100, 1'b0, 33);
    issue(OP_MUL, 32'd12345, 32'd678, 32'h007F_B6F6, 4'b0000, 1'b0, 33);
    issue(OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 4'b1000, 1'b0, 33);
    issue(OP_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 4'b1000, 1'b1, 1);
    issue(OP_MOD, 32'd9, 32'd0, 32'd9, 4'b0000, 1'b1, 1);
    drain();

    // in_valid stays high and operands change while the multiply is iterating
    wait_ready();
    opcode   = OP_MUL;
    a        = 32'd3;
    b        = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    e.res = 32'd15; e.flg = 4'b0000; e.dbz = 1'b0; e.lat = 33; e.t_acc = $time;
    exp_q.push_back(e);
    #1;
    a      = 32'd100;
    b      = 32'd100;
    opcode = OP_ADD;
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    chk("held_out_valid_seen", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("held_no_second_accept", 64'(busy), 64'd0);

    // consumer stalls for 5 cycles while the result sits in DONE
    out_ready = 1'b0;
    issue(OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b0, 1);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("bp_still_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    drain();

    // reset in the middle of a divide discards it
    wait_ready();
    opcode   = OP_DIV;
    a        = 32'd100;
    b        = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    issue(OP_ADD, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
